prog_loader: RTL

Byte-stream program loader for the 8-bit accumulator processor: writes instruction bytes ({opcode[2:0], immediate[4:0]}) into program memory from address 0 upward. The processor holds the CPU until the load completes, and the loader then releases it so it can fetch from address 0. The loader sits between an external byte source (host/UART front end) and the write port of `memory`. It is the writer of the instruction fetch path.

---
 rtl/loader_pkg.sv | 24 ++
 rtl/prog_loader_if.sv | 27 ++
 rtl/ld_csum.sv | 21 ++
 rtl/prog_loader.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// State encoding, length decode rule and default widths.
package loader_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam bit LEN_ZERO_MEANS_256 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic logic [8:0] len_decode(input logic [7:0] b);
    if (b == 8'd0 && LEN_ZERO_MEANS_256)
      return 9'd256;
    return {1'b0, b};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
// master = source/memory side, slave = loader.
interface prog_loader_if
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_addr, mem_din, mem_we
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_addr, mem_din, mem_we
  );

endinterface

// File: rtl/ld_csum.sv
// 8-bit running-sum accumulator with clear and add-enable.
// Used only when LOADER_CHECKSUM_EN is defined.
module ld_csum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      sum <= '0;
    else if (add)
      sum <= sum + din;
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: length byte, N data bytes, optional checksum.
// Optional trailing checksum byte under `define LOADER_CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  prog_loader_if.slave bus,
  output logic       cpu_hold,
  output logic       done,
  output logic       error,
  output logic [8:0] count
);

  state_t            state;
  logic [8:0]        len;
  logic [DATA_W-1:0] byte_in;
  logic              acc;
  logic              last;

  assign byte_in = bus.in_data;
  assign acc     = bus.in_valid && bus.in_ready;
  assign last    = (count + 9'd1) == len;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              csum_clr;
  logic              err_q;

  assign csum_clr = start &&
    (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

  ld_csum #(.W(DATA_W)) u_csum (
    .clk (clk),
    .rst (rst),
    .clr (csum_clr),
    .add (acc && state == ST_DATA),
    .din (byte_in),
    .sum (sum)
  );

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      len          <= '0;
      count        <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      bus.in_ready <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
`ifdef LOADER_CHECKSUM_EN
      err_q        <= 1'b0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_LEN;
            bus.in_ready <= 1'b1;
          end
        end
        ST_LEN: begin
          if (acc) begin
            len   <= len_decode(byte_in);
            count <= '0;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (acc) begin
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= ADDR_W'(count);
            bus.mem_din  <= byte_in;
            count        <= count + 9'd1;
`ifdef LOADER_CHECKSUM_EN
            if (last)
              state <= ST_CSUM;
`else
            // done is raised by DONE itself, after the last mem_we cycle
            if (last) begin
              state        <= ST_DONE;
              bus.in_ready <= 1'b0;
            end
`endif
          end
        end
        ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
          if (acc) begin
            bus.in_ready <= 1'b0;
            if (byte_in == sum) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERR;
              err_q <= 1'b1;
            end
          end
`else
          state <= ST_IDLE;
`endif
        end
        ST_DONE: begin
          if (start) begin
            state        <= ST_LEN;
            bus.in_ready <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
          end else begin
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end
        end
        ST_ERR: begin
          if (start) begin
            state        <= ST_LEN;
            bus.in_ready <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            err_q        <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule
